// File: rtl/addepreamble.sv
// Prepends seven preamble octets and the SFD to each transmit frame.
// Frame octets are held in an 8-deep delay line while the preamble goes out.
module addepreamble #(
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0] SFD_BYTE      = 8'hd5
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_v,
  output logic [7:0] o_d
);

  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic            bypass_reg, bypass_next;
  logic            o_v_reg, o_v_next;
  logic [7:0]      o_d_reg, o_d_next;
  logic [7:0]      dl_v_reg, dl_v_next, dl_v_shift;
  logic [7:0][7:0] dl_d_reg, dl_d_next, dl_d_shift;
  logic            push;
  logic            push_v;
  logic [7:0]      push_d;

  // Entry 0 takes the new octet; entry 7 is the tail popped in DATA.
  assign dl_v_shift[0] = push_v;
  assign dl_d_shift[0] = push_d;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_shift
      assign dl_v_shift[gi] = dl_v_reg[gi-1];
      assign dl_d_shift[gi] = dl_d_reg[gi-1];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bypass_next = bypass_reg;
    o_v_next    = o_v_reg;
    o_d_next    = o_d_reg;
    push        = 1'b0;
    push_v      = i_v;
    push_d      = i_d;
    case (state_reg)
      IDLE: begin
        if (i_v) begin
          o_v_next = 1'b1;
          if (i_en) begin
            push       = 1'b1;
            o_d_next   = PREAMBLE_BYTE;
            cnt_next   = 3'd1;
            state_next = PRE;
          end else begin
            bypass_next = 1'b1;
            o_d_next    = i_d;
            state_next  = DATA;
          end
        end else begin
          o_v_next = 1'b0;
          o_d_next = 8'h00;
        end
      end
      PRE: begin
        push     = 1'b1;
        o_v_next = 1'b1;
        if (cnt_reg == 3'd7) begin
          o_d_next   = SFD_BYTE;
          state_next = DATA;
        end else begin
          o_d_next = PREAMBLE_BYTE;
          cnt_next = cnt_reg + 3'd1;
        end
      end
      DATA: begin
        if (bypass_reg) begin
          o_v_next = i_v;
          o_d_next = i_v ? i_d : 8'h00;
          if (!i_v) begin
            bypass_next = 1'b0;
            state_next  = IDLE;
          end
        end else begin
          // Gaps inside the line keep us here, so a closely following frame drains through.
          push     = 1'b1;
          o_v_next = dl_v_reg[7];
          o_d_next = dl_v_reg[7] ? dl_d_reg[7] : 8'h00;
          if (dl_v_reg == 8'h00) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    dl_v_next = push ? dl_v_shift : dl_v_reg;
    dl_d_next = push ? dl_d_shift : dl_d_reg;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      bypass_reg <= 1'b0;
      o_v_reg    <= 1'b0;
      o_d_reg    <= 8'h00;
      dl_v_reg   <= '0;
      dl_d_reg   <= '0;
    end else if (i_ce) begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bypass_reg <= bypass_next;
      o_v_reg    <= o_v_next;
      o_d_reg    <= o_d_next;
      dl_v_reg   <= dl_v_next;
      dl_d_reg   <= dl_d_next;
    end
  end

  assign o_v = o_v_reg;
  assign o_d = o_d_reg;

endmodule

// File: tb/tb_addepreamble.sv
// Scoreboard bench for addepreamble: stimulus queues expected octets and run
// lengths, a monitor checks every enabled output cycle against them.
module tb_addepreamble;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_ce = 1'b0;
  logic       i_en = 1'b0;
  logic       i_v = 1'b0;
  logic [7:0] i_d = 8'h00;
  logic       o_v;
  logic [7:0] o_d;

  int n_cmp = 0;
  int n_bad = 0;
  int ce_period = 1;

  logic [7:0] exp_q[$];
  int         run_q[$];

  addepreamble dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_ce     (i_ce),
    .i_en     (i_en),
    .i_v      (i_v),
    .i_d      (i_d),
    .o_v      (o_v),
    .o_d      (o_d)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One octet time: i_ce high for the first clock, low for the rest.
  task automatic tick(input logic v, input logic [7:0] d);
    for (int k = 0; k < ce_period; k++) begin
      @(negedge i_clk);
      i_ce = (k == 0);
      i_v  = v;
      i_d  = d;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 8'h00);
  endtask

  task automatic push_pre();
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hd5);
  endtask

  // Monitor: compares each valid octet and each completed run length.
  initial begin
    logic       ce_s, rst_s, prev_v;
    logic [7:0] prev_d;
    int         run;
    run = 0;
    prev_v = 1'b0;
    prev_d = 8'h00;
    forever begin
      @(posedge i_clk);
      ce_s  = i_ce;
      rst_s = i_reset_n;
      #1;
      if (!rst_s || !i_reset_n) begin
        run = 0;
      end else if (ce_s) begin
        if (o_v) begin
          run++;
          if (exp_q.size() == 0) begin
            check("unexpected_octet", o_d, 256);
          end else begin
            check("octet", o_d, exp_q.pop_front());
          end
        end else begin
          check("idle_data", o_d, 0);
          if (run > 0) begin
            if (run_q.size() == 0) check("unexpected_run", run, 0);
            else check("run_length", run, run_q.pop_front());
            run = 0;
          end
        end
      end else begin
        check("hold_v", o_v, prev_v);
        check("hold_d", o_d, prev_d);
      end
      prev_v = o_v;
      prev_d = o_d;
    end
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check("reset_v", o_v, 0);
    check("reset_d", o_d, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(4);

    // Basic 4-octet frame
    i_en = 1'b1;
    push_pre();
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    run_q.push_back(12);
    for (int k = 1; k <= 4; k++) tick(1'b1, 8'(k));
    idle(12);
    $display("frame basic4 issued");

    // Sparse clock enable
    ce_period = 4;
    push_pre();
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    run_q.push_back(12);
    for (int k = 1; k <= 4; k++) tick(1'b1, 8'(k));
    idle(12);
    ce_period = 1;
    $display("frame sparse_ce issued");

    // Pass-through
    i_en = 1'b0;
    exp_q.push_back(8'haa);
    exp_q.push_back(8'hbb);
    exp_q.push_back(8'hcc);
    run_q.push_back(3);
    tick(1'b1, 8'haa);
    tick(1'b1, 8'hbb);
    tick(1'b1, 8'hcc);
    idle(12);
    $display("frame bypass issued");

    // Long frame then 1-octet frame
    i_en = 1'b1;
    push_pre();
    for (int k = 0; k < 64; k++) exp_q.push_back(8'(k));
    run_q.push_back(72);
    for (int k = 0; k < 64; k++) tick(1'b1, 8'(k));
    idle(12);
    push_pre();
    exp_q.push_back(8'hee);
    run_q.push_back(9);
    tick(1'b1, 8'hee);
    idle(12);
    $display("frames long64 and short1 issued");

    // Reset during preamble octet 5
    push_pre();
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h98);
    run_q.push_back(10);
    tick(1'b1, 8'h99);
    tick(1'b1, 8'h98);
    idle(3);
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    check("async_reset_v", o_v, 0);
    check("async_reset_d", o_d, 0);
    exp_q.delete();
    run_q.delete();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(2);
    push_pre();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    run_q.push_back(10);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    idle(12);
    $display("frame after reset issued");

    // i_en drops mid-frame; second frame two cycles later drains with no preamble
    i_en = 1'b1;
    push_pre();
    for (int k = 0; k < 10; k++) exp_q.push_back(8'ha0 + 8'(k));
    run_q.push_back(18);
    exp_q.push_back(8'hc1);
    exp_q.push_back(8'hc2);
    exp_q.push_back(8'hc3);
    run_q.push_back(3);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) i_en = 1'b0;
      tick(1'b1, 8'ha0 + 8'(k));
    end
    idle(2);
    tick(1'b1, 8'hc1);
    tick(1'b1, 8'hc2);
    tick(1'b1, 8'hc3);
    idle(16);
    $display("frames en_toggle and short_gap issued");

    check("octets_left", exp_q.size(), 0);
    check("runs_left", run_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
